servo_pulse_gen: RTL and testbench

Consumes the 4-bit motion codes produced by the switch/fire command FSM (x, y and fire channels) and turns them into a standard hobby-servo PWM waveform. Each instance drives one servo. It keeps a saturating pulse-width position register that the command code updates once per PWM frame, so the pulse never glitches mid-frame. Three instances sit between the command FSM and the servo header pins: pan, tilt and trigger.

---
 rtl/servo_pulse_gen_if.sv | 15 +
 rtl/servo_pulse_gen.sv | 125 ++++++++++++
 tb/tb_servo_pulse_gen.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/servo_pulse_gen_if.sv
// Command/output bundle between the motion-command FSM and one servo pulse generator.
// The command source drives i_Cmd; the generator drives the pulse and position outputs.
interface servo_pulse_gen_if #(
  parameter int W = 19
);
  logic [3:0]   i_Cmd;
  logic         o_Pwm;
  logic [W-1:0] o_Pos;
  logic         o_Frame;
  logic         o_At_Min;
  logic         o_At_Max;

  modport master (output i_Cmd, input o_Pwm, o_Pos, o_Frame, o_At_Min, o_At_Max);
  modport slave  (input i_Cmd, output o_Pwm, o_Pos, o_Frame, o_At_Min, o_At_Max);
endinterface

// File: rtl/servo_pulse_gen.sv
// Hobby-servo PWM generator: one pulse per frame, width taken from a saturating
// position register that the motion code updates only at frame boundaries.
module servo_pulse_gen #(
  parameter int PERIOD_CYC = 500000,
  parameter int MIN_CYC    = 25000,
  parameter int MAX_CYC    = 50000,
  parameter int STEP_CYC   = 250,
  parameter int RESET_POS  = 37500,
  parameter int ABSOLUTE   = 0
) (
  input logic             i_Clk,
  input logic             i_Rst,
  servo_pulse_gen_if.slave bus
);
  localparam int W = $clog2(PERIOD_CYC);

  localparam logic [W:0]   MIN_X    = (W+1)'(MIN_CYC);
  localparam logic [W:0]   MAX_X    = (W+1)'(MAX_CYC);
  localparam logic [W:0]   STEP_X   = (W+1)'(STEP_CYC);
  localparam logic [W-1:0] MIN_W    = W'(MIN_CYC);
  localparam logic [W-1:0] MAX_W    = W'(MAX_CYC);
  localparam logic [W-1:0] RST_W    = W'(RESET_POS);
  localparam logic [W-1:0] CNT_LAST = W'(PERIOD_CYC - 1);

  // ST_PEND is the post-reset wait: the first edge opens a frame without sampling i_Cmd.
  typedef enum logic [1:0] {ST_PEND, ST_HIGH, ST_LOW} state_t;

  state_t       state_r;
  logic [W-1:0] cnt_r;
  logic [W-1:0] cnt_inc_s;
  logic [W-1:0] pos_r;
  logic [W-1:0] next_pos_s;
  logic [W:0]   pos_x_s;
  logic [W:0]   sum_s;
  logic [W:0]   diff_s;
  logic         pwm_r;
  logic         frame_r;
  logic         at_min_r;
  logic         at_max_r;

  assign cnt_inc_s = cnt_r + W'(1);

  // Candidate position for the next frame; arithmetic is one bit wider so clamps see the true value.
  always_comb begin
    pos_x_s    = {1'b0, pos_r};
    sum_s      = pos_x_s + STEP_X;
    diff_s     = pos_x_s - STEP_X;
    next_pos_s = pos_r;
    if (ABSOLUTE != 0) begin
      case (bus.i_Cmd)
        4'd1:    next_pos_s = MAX_W;
        4'd2:    next_pos_s = MIN_W;
        default: next_pos_s = pos_r;
      endcase
    end else begin
      case (bus.i_Cmd)
        4'd1: begin
          if ((pos_x_s < STEP_X) || (diff_s < MIN_X)) begin
            next_pos_s = MIN_W;
          end else begin
            next_pos_s = diff_s[W-1:0];
          end
        end
        4'd2: begin
          if (sum_s > MAX_X) begin
            next_pos_s = MAX_W;
          end else begin
            next_pos_s = sum_s[W-1:0];
          end
        end
        default: next_pos_s = pos_r;
      endcase
    end
  end

  // Frame counter, pulse FSM and registered outputs.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_r  <= ST_PEND;
      cnt_r    <= '0;
      pos_r    <= RST_W;
      pwm_r    <= 1'b0;
      frame_r  <= 1'b0;
      at_min_r <= (RESET_POS == MIN_CYC);
      at_max_r <= (RESET_POS == MAX_CYC);
    end else begin
      case (state_r)
        ST_PEND: begin
          state_r <= ST_HIGH;
          cnt_r   <= '0;
          pwm_r   <= 1'b1;
          frame_r <= 1'b1;
        end
        default: begin
          if (cnt_r == CNT_LAST) begin
            // Frame boundary: the command held before this edge sets this frame's width.
            state_r  <= ST_HIGH;
            cnt_r    <= '0;
            pos_r    <= next_pos_s;
            at_min_r <= (next_pos_s == MIN_W);
            at_max_r <= (next_pos_s == MAX_W);
            pwm_r    <= 1'b1;
            frame_r  <= 1'b1;
          end else begin
            cnt_r   <= cnt_inc_s;
            frame_r <= 1'b0;
            if ((state_r == ST_HIGH) && (cnt_inc_s == pos_r)) begin
              state_r <= ST_LOW;
              pwm_r   <= 1'b0;
            end else begin
              state_r <= state_r;
              pwm_r   <= (state_r == ST_HIGH);
            end
          end
        end
      endcase
    end
  end

  assign bus.o_Pwm    = pwm_r;
  assign bus.o_Pos    = pos_r;
  assign bus.o_Frame  = frame_r;
  assign bus.o_At_Min = at_min_r;
  assign bus.o_At_Max = at_max_r;
endmodule

// File: tb/tb_servo_pulse_gen.sv
// Randomized bench for servo_pulse_gen: an incremental and an absolute instance
// checked every cycle against a frame-level model, plus literal pins on the model.
module tb_servo_pulse_gen;
  localparam int PER  = 100;
  localparam int MIN  = 10;
  localparam int MAX  = 20;
  localparam int STEP = 3;
  localparam int W    = $clog2(PER);

  logic i_Clk = 1'b0;
  logic i_Rst;

  servo_pulse_gen_if #(.W(W)) if_inc ();
  servo_pulse_gen_if #(.W(W)) if_abs ();

  servo_pulse_gen #(.PERIOD_CYC(PER), .MIN_CYC(MIN), .MAX_CYC(MAX), .STEP_CYC(STEP),
                    .RESET_POS(15), .ABSOLUTE(0))
    dut_inc (.i_Clk(i_Clk), .i_Rst(i_Rst), .bus(if_inc.slave));

  servo_pulse_gen #(.PERIOD_CYC(PER), .MIN_CYC(MIN), .MAX_CYC(MAX), .STEP_CYC(STEP),
                    .RESET_POS(10), .ABSOLUTE(1))
    dut_abs (.i_Clk(i_Clk), .i_Rst(i_Rst), .bus(if_abs.slave));

  always #5 i_Clk = ~i_Clk;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: edge index since release, whether e=0 has happened, frame widths.
  int m_e       = 0;
  bit m_started = 1'b0;
  int m_w[2]    = '{15, 10};
  int cur       = -1;

  function automatic int rpos(input int k);
    return (k == 0) ? 15 : 10;
  endfunction

  function automatic int upd(input int w, input int c, input bit absm);
    if (absm) begin
      if (c == 1) return MAX;
      if (c == 2) return MIN;
      return w;
    end
    if (c == 1) return (w - STEP < MIN) ? MIN : w - STEP;
    if (c == 2) return (w + STEP > MAX) ? MAX : w + STEP;
    return w;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_inst(input string nm, input int k, input logic pwm, input logic frm,
                            input logic [W-1:0] pos, input logic mn, input logic mx);
    int  p;
    logic epwm, efrm;
    if (i_Rst || !m_started) begin
      epwm = 1'b0;
      efrm = 1'b0;
    end else begin
      p    = m_e % PER;
      epwm = (p < m_w[k]);
      efrm = (p == 0);
    end
    chk({nm, ".pwm"},    32'(pwm), 32'(epwm));
    chk({nm, ".frame"},  32'(frm), 32'(efrm));
    chk({nm, ".pos"},    32'(pos), 32'(m_w[k]));
    chk({nm, ".at_min"}, 32'(mn),  32'(m_w[k] == MIN));
    chk({nm, ".at_max"}, 32'(mx),  32'(m_w[k] == MAX));
  endtask

  // Reference model: advances on every edge, resets asynchronously.
  initial begin
    forever begin
      @(posedge i_Clk or posedge i_Rst);
      if (i_Rst) begin
        m_started = 1'b0;
        m_w[0]    = rpos(0);
        m_w[1]    = rpos(1);
      end else if (!m_started) begin
        m_started = 1'b1;
        m_e       = 0;
      end else begin
        m_e++;
        if (m_e % PER == 0) begin
          m_w[0] = upd(m_w[0], int'(if_inc.i_Cmd), 1'b0);
          m_w[1] = upd(m_w[1], int'(if_abs.i_Cmd), 1'b1);
        end
      end
    end
  end

  // Every-cycle comparison, away from the active edge.
  initial begin
    forever begin
      @(negedge i_Clk);
      check_inst("inc", 0, if_inc.o_Pwm, if_inc.o_Frame, if_inc.o_Pos, if_inc.o_At_Min, if_inc.o_At_Max);
      check_inst("abs", 1, if_abs.o_Pwm, if_abs.o_Frame, if_abs.o_Pos, if_abs.o_At_Min, if_abs.o_At_Max);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_Clk);
      #2;
      cur++;
    end
  endtask

  // Leaves the bench just after edge E-1, so whatever is driven now is sampled at edge E.
  task automatic wait_before(input int e);
    while (cur < e - 1) tick(1);
  endtask

  task automatic wait_after(input int e);
    while (cur < e) tick(1);
  endtask

  task automatic do_reset;
    i_Rst = 1'b1;
    tick(3);
    i_Rst = 1'b0;
    cur   = -1;
  endtask

  initial begin
    int rc;
    i_Rst        = 1'b1;
    if_inc.i_Cmd = 4'd0;
    if_abs.i_Cmd = 4'd0;

    // Idle frames: 15-wide pulses, frame strobes every 100 edges.
    do_reset();
    wait_after(0);
    chk("pin.e0.frame", 32'(if_inc.o_Frame), 32'd1);
    chk("pin.e0.pwm",   32'(if_inc.o_Pwm),   32'd1);
    chk("pin.e0.pos",   32'(if_inc.o_Pos),   32'd15);
    chk("pin.e0.abs_min", 32'(if_abs.o_At_Min), 32'd1);
    wait_after(14);
    chk("pin.e14.pwm", 32'(if_inc.o_Pwm), 32'd1);
    wait_after(15);
    chk("pin.e15.pwm", 32'(if_inc.o_Pwm), 32'd0);
    wait_after(99);
    chk("pin.e99.frame", 32'(if_inc.o_Frame), 32'd0);
    wait_after(100);
    chk("pin.e100.frame", 32'(if_inc.o_Frame), 32'd1);
    wait_after(200);
    chk("pin.e200.pos", 32'(if_inc.o_Pos), 32'd15);
    chk("pin.e200.lim", 32'({if_inc.o_At_Min, if_inc.o_At_Max}), 32'd0);

    // Increment to saturation; absolute jumps to max then min.
    do_reset();
    wait_before(50);
    if_inc.i_Cmd = 4'd2;
    wait_before(100);
    if_abs.i_Cmd = 4'd1;
    wait_after(100);
    if_abs.i_Cmd = 4'd0;
    chk("pin.inc.w100", 32'(if_inc.o_Pos), 32'd18);
    chk("pin.abs.w100", 32'(if_abs.o_Pos), 32'd20);
    wait_after(199);
    chk("pin.inc.max199", 32'(if_inc.o_At_Max), 32'd0);
    if_abs.i_Cmd = 4'd2;
    wait_after(200);
    if_abs.i_Cmd = 4'd0;
    chk("pin.inc.w200", 32'(if_inc.o_Pos), 32'd20);
    chk("pin.inc.max200", 32'(if_inc.o_At_Max), 32'd1);
    chk("pin.abs.w200", 32'(if_abs.o_Pos), 32'd10);
    wait_after(300);
    chk("pin.inc.w300", 32'(if_inc.o_Pos), 32'd20);
    chk("pin.abs.w300", 32'(if_abs.o_Pos), 32'd10);

    // Decrement held from reset; absolute side gets random codes.
    if_inc.i_Cmd = 4'd1;
    do_reset();
    while (cur < 300) begin
      if_abs.i_Cmd = 4'($urandom_range(0, 15));
      tick(1);
    end
    if_abs.i_Cmd = 4'd0;
    chk("pin.dec.w300", 32'(if_inc.o_Pos), 32'd10);
    chk("pin.dec.min300", 32'(if_inc.o_At_Min), 32'd1);

    // Mid-frame pulse and a release code at a frame boundary both leave width 15.
    if_inc.i_Cmd = 4'd0;
    do_reset();
    wait_before(40);
    if_inc.i_Cmd = 4'd2;
    wait_before(61);
    if_inc.i_Cmd = 4'd0;
    wait_before(100);
    if_inc.i_Cmd = 4'd5;
    wait_after(100);
    if_inc.i_Cmd = 4'd0;
    chk("pin.glitch.w100", 32'(if_inc.o_Pos), 32'd15);
    wait_after(200);
    chk("pin.glitch.w200", 32'(if_inc.o_Pos), 32'd15);

    // Reset during a width-18 frame.
    do_reset();
    wait_before(100);
    if_inc.i_Cmd = 4'd2;
    wait_after(100);
    if_inc.i_Cmd = 4'd0;
    wait_after(105);
    chk("pin.pre_rst.pwm", 32'(if_inc.o_Pwm), 32'd1);
    chk("pin.pre_rst.pos", 32'(if_inc.o_Pos), 32'd18);
    i_Rst = 1'b1;
    #1;
    chk("pin.rst.pwm", 32'(if_inc.o_Pwm), 32'd0);
    chk("pin.rst.pos", 32'(if_inc.o_Pos), 32'd15);
    tick(2);
    i_Rst = 1'b0;
    cur   = -1;
    wait_after(0);
    chk("pin.rel.pwm", 32'(if_inc.o_Pwm), 32'd1);
    chk("pin.rel.frame", 32'(if_inc.o_Frame), 32'd1);
    chk("pin.rel.pos", 32'(if_inc.o_Pos), 32'd15);

    // Random codes, biased toward motion, with one random mid-run reset.
    rc = $urandom_range(300, 1200);
    for (int i = 0; i < 1600; i++) begin
      if_inc.i_Cmd = 4'($urandom_range(0, 15));
      if_abs.i_Cmd = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) if_inc.i_Cmd = 4'($urandom_range(1, 2));
      if ($urandom_range(0, 3) == 0) if_abs.i_Cmd = 4'($urandom_range(1, 2));
      if (i == rc) begin
        do_reset();
      end else begin
        tick(1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
